// File: rtl/ppu_dp_ram.sv
// Dual-port synchronous RAM for the PPU with clock enable, registered read data,
// selectable read-first/write-first behaviour and an optional post-reset hardware clear.
module ppu_dp_ram #(
    parameter int unsigned           DATA_WIDTH     = 8,
    parameter int unsigned           ADDR_WIDTH     = 11,
    parameter int unsigned           READ_MODE      = 0,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic [DATA_WIDTH-1:0] din_a,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic [DATA_WIDTH-1:0] dout_a,
    output logic [DATA_WIDTH-1:0] dout_b,
    output logic                  busy
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_dout_a;
    logic [DATA_WIDTH-1:0] r_dout_b;
    logic                  r_busy;

    logic                  w_clearing;
    logic                  w_same_addr;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;

    assign w_clearing  = (r_state == ST_CLEAR);
    assign w_same_addr = (addr_a == addr_b);

    // Write-first forwards this cycle's write data; port A wins an address collision.
    always_comb begin
        w_rd_a = r_mem[addr_a];
        w_rd_b = r_mem[addr_b];
        if (READ_MODE != 0) begin
            if (we_a)
                w_rd_a = din_a;
            else if (we_b && w_same_addr)
                w_rd_a = din_b;
            if (we_a && w_same_addr)
                w_rd_b = din_a;
            else if (we_b)
                w_rd_b = din_b;
        end
    end

    // Memory array has no reset; only the clear sequence initialises it.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (w_clearing) begin
                r_mem[r_clr_cnt] <= CLEAR_VALUE;
            end else begin
                if (we_b)
                    r_mem[addr_b] <= din_b;
                if (we_a)
                    r_mem[addr_a] <= din_a;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            r_busy    <= CLEAR_ON_RESET;
            r_clr_cnt <= '0;
            r_dout_a  <= '0;
            r_dout_b  <= '0;
        end else if (clk_en) begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    r_dout_a  <= '0;
                    r_dout_b  <= '0;
                    if (r_clr_cnt == '1) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_dout_a <= w_rd_a;
                    r_dout_b <= w_rd_b;
                end
            endcase
        end
    end

    assign dout_a = r_dout_a;
    assign dout_b = r_dout_b;
    assign busy   = r_busy;

endmodule

// File: tb/tb_ppu_dp_ram.sv
// Directed self-checking bench for ppu_dp_ram: read-first and write-first default-size
// instances on shared stimulus, plus 16x32 instances with and without the hardware clear.
module tb_ppu_dp_ram;

    logic        clk;
    logic        rst_n;
    logic        clk_en;

    logic [10:0] addr_a, addr_b;
    logic        we_a, we_b;
    logic [7:0]  din_a, din_b;
    logic [7:0]  dout_a0, dout_b0, dout_a1, dout_b1;
    logic        busy0, busy1;

    logic [4:0]  addr2_a, addr2_b;
    logic        we2_a, we2_b;
    logic [15:0] din2_a, din2_b;
    logic [15:0] dout_a2, dout_b2, dout_a3, dout_b3;
    logic        busy2, busy3;

    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned n_busy0, n_busy2, n_busy3, n_bad_dout;

    ppu_dp_ram #(.READ_MODE(0)) u_dut_rf (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .addr_a(addr_a), .addr_b(addr_b), .we_a(we_a), .we_b(we_b),
        .din_a(din_a), .din_b(din_b), .dout_a(dout_a0), .dout_b(dout_b0), .busy(busy0)
    );

    ppu_dp_ram #(.READ_MODE(1)) u_dut_wf (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .addr_a(addr_a), .addr_b(addr_b), .we_a(we_a), .we_b(we_b),
        .din_a(din_a), .din_b(din_b), .dout_a(dout_a1), .dout_b(dout_b1), .busy(busy1)
    );

    ppu_dp_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .CLEAR_VALUE(16'hBEEF)) u_dut_w16 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .addr_a(addr2_a), .addr_b(addr2_b), .we_a(we2_a), .we_b(we2_b),
        .din_a(din2_a), .din_b(din2_b), .dout_a(dout_a2), .dout_b(dout_b2), .busy(busy2)
    );

    ppu_dp_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .CLEAR_ON_RESET(1'b0)) u_dut_noclr (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .addr_a(addr2_a), .addr_b(addr2_b), .we_a(we2_a), .we_b(we2_b),
        .din_a(din2_a), .din_b(din2_b), .dout_a(dout_a3), .dout_b(dout_b3), .busy(busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One PPU-rate enabled edge followed by three idle master clocks; returns 1 unit after an edge.
    task automatic step();
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n  = 1'b0;
        clk_en = 1'b0;
        addr_a = '0; addr_b = '0; we_a = 1'b0; we_b = 1'b0; din_a = '0; din_b = '0;
        addr2_a = '0; addr2_b = '0; we2_a = 1'b0; we2_b = 1'b0; din2_a = '0; din2_b = '0;

        repeat (3) @(posedge clk);
        #2;
        check("rst_dout_a", dout_a0, 0);
        check("rst_dout_b", dout_b0, 0);
        check("rst_busy", busy0, 1);
        check("rst_busy_wf", busy1, 1);
        check("rst_busy_w16", busy2, 1);
        check("rst_busy_noclr", busy3, 0);
        #1 rst_n = 1'b1;

        // Clear with writes attempted on both ports; they must be ignored.
        we_a = 1'b1; addr_a = 11'h3FF; din_a = 8'hAA;
        we_b = 1'b1; addr_b = 11'h7FF; din_b = 8'hBB;
        n_busy0 = 0; n_busy2 = 0; n_busy3 = 0; n_bad_dout = 0;
        for (int k = 0; k < 2200 && busy0 == 1'b1; k++) begin
            n_busy0++;
            if (busy2) n_busy2++;
            if (busy3) n_busy3++;
            if (dout_a0 != 0 || dout_b0 != 0 || dout_a1 != 0 || dout_b1 != 0) n_bad_dout++;
            step();
        end
        we_a = 1'b0; we_b = 1'b0;
        check("clear_cycles", n_busy0, 2048);
        check("clear_cycles_w16", n_busy2, 32);
        check("clear_cycles_noclr", n_busy3, 0);
        check("clear_dout_zero", n_bad_dout, 0);
        check("ready_busy_wf", busy1, 0);

        addr_a = 11'h000; addr_b = 11'h3FF;
        step();
        check("rd_0x000", dout_a0, 8'h00);
        check("rd_0x3FF", dout_b0, 8'h00);
        addr_a = 11'h7FF;
        step();
        check("rd_0x7FF", dout_a0, 8'h00);
        check("rd_0x7FF_wf", dout_a1, 8'h00);

        for (int i = 0; i < 32; i++) begin
            addr2_a = 5'(i);
            addr2_b = 5'(31 - i);
            step();
            check("w16_clr_a", dout_a2, 16'hBEEF);
            check("w16_clr_b", dout_b2, 16'hBEEF);
        end

        // No-clear instance is usable straight out of reset.
        we2_a = 1'b1; addr2_a = 5'd7; din2_a = 16'h1234;
        step();
        we2_a = 1'b0; addr2_b = 5'd7;
        step();
        check("noclr_rd_a", dout_a3, 16'h1234);
        check("noclr_rd_b", dout_b3, 16'h1234);

        // A writes, B reads the same address.
        we_a = 1'b1; addr_a = 11'h123; din_a = 8'h5A; addr_b = 11'h123;
        step();
        check("rf_b_old", dout_b0, 8'h00);
        check("rf_a_old", dout_a0, 8'h00);
        check("wf_b_new", dout_b1, 8'h5A);
        check("wf_a_new", dout_a1, 8'h5A);
        we_a = 1'b0;
        step();
        check("rf_b_after", dout_b0, 8'h5A);

        // B writes, A reads the same address.
        we_b = 1'b1; addr_b = 11'h124; din_b = 8'h3C; addr_a = 11'h124;
        step();
        check("rf_a_bwr", dout_a0, 8'h00);
        check("wf_a_bwr", dout_a1, 8'h3C);
        we_b = 1'b0;

        // Collision: port A priority.
        we_a = 1'b1; we_b = 1'b1; addr_a = 11'h040; addr_b = 11'h040; din_a = 8'h11; din_b = 8'h22;
        step();
        check("coll_wf_a", dout_a1, 8'h11);
        check("coll_wf_b", dout_b1, 8'h11);
        check("coll_rf_a", dout_a0, 8'h00);
        we_a = 1'b0; we_b = 1'b0;
        step();
        check("coll_mem_a", dout_a0, 8'h11);
        check("coll_mem_b", dout_b0, 8'h11);

        // Independent writes to different addresses.
        we_a = 1'b1; we_b = 1'b1; addr_a = 11'h200; addr_b = 11'h201; din_a = 8'h33; din_b = 8'h44;
        step();
        we_a = 1'b0; we_b = 1'b0; addr_a = 11'h201; addr_b = 11'h200;
        step();
        check("dual_wr_a", dout_a0, 8'h44);
        check("dual_wr_b", dout_b0, 8'h33);

        // Clock enable low: nothing may change.
        we_a = 1'b1; addr_a = 11'h010; din_a = 8'hFF; addr_b = 11'h010;
        repeat (10) @(posedge clk);
        #1;
        check("hold_dout_a", dout_a0, 8'h44);
        check("hold_dout_b", dout_b0, 8'h33);
        we_a = 1'b0;
        step();
        check("hold_mem", dout_a0, 8'h00);

        // Asynchronous reset from READY with non-zero outputs.
        addr_a = 11'h123; addr_b = 11'h040; addr2_a = 5'd7;
        step();
        check("pre_rst_a", dout_a0, 8'h5A);
        check("pre_rst_b", dout_b0, 8'h11);
        #2 rst_n = 1'b0;
        #1;
        check("async_dout_a", dout_a0, 8'h00);
        check("async_dout_b", dout_b0, 8'h00);
        check("async_busy", busy0, 1);
        check("async_noclr", dout_a3, 16'h0000);
        #2 rst_n = 1'b1;

        repeat (500) step();
        check("mid_clear_busy", busy0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy0, 1);
        check("mid_rst_dout", dout_a0, 8'h00);
        #2 rst_n = 1'b1;

        n_busy0 = 0;
        for (int k = 0; k < 2200 && busy0 == 1'b1; k++) begin
            n_busy0++;
            step();
        end
        check("reclear_cycles", n_busy0, 2048);
        step();
        check("reclear_mem", dout_a0, 8'h00);
        check("reclear_mem_b", dout_b0, 8'h00);
        check("noclr_retain", dout_a3, 16'h1234);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
